// File: rtl/traffic_input_cond.sv
// Input conditioning for the traffic-light controller: synchronizes and
// debounces the two road detectors and the two parade buttons. It turns button
// presses into single-cycle requests and keeps saturating per-road vehicle
// counts.
module traffic_input_cond #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             btn_p,
    input  logic             btn_r,
    input  logic             cnt_clr,
    output logic             t_a,
    output logic             t_b,
    output logic             p,
    output logic             r,
    output logic             conflict,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // Channel order inside the 4-bit vectors.
    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_P = 2;
    localparam int CH_R = 3;
    localparam int N_CH = 4;

    // A debounce counter runs from 0 to DB_CYCLES-1, so ceil(log2(DB_CYCLES)) bits are enough.
    localparam int                DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [N_CH-1:0] raw_vec;
    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;
    logic [N_CH-1:0] deb_q;
    logic [N_CH-1:0] deb_prev_q;
    logic [N_CH-1:0] rise;
    logic [DB_W-1:0] db_cnt_q [N_CH];

    logic             p_q;
    logic             r_q;
    logic             conflict_q;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;

    assign raw_vec = {btn_r, btn_p, raw_b, raw_a};

    // Two-flop synchronizer on every asynchronous input.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so that every flop
        // samples the values from before the edge, whatever order the
        // statements are written in.
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_vec;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: a channel changes state only after the synced input has
    // differed from it for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            // NOTE: the counter array is a small set of flops, not a RAM.
            // It must be cleared on reset so that a reset in the middle of
            // operation discards any partial debounce count.
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_q2[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= sync_q2[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Previous debounced value, used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev_q <= '0;
        end else begin
            deb_prev_q <= deb_q;
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    // Registered button requests. If both buttons rise together, the
    // controller receives a conflict flag instead of either request.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            p_q        <= rise[CH_P] & ~rise[CH_R];
            r_q        <= rise[CH_R] & ~rise[CH_P];
            conflict_q <= rise[CH_P] &  rise[CH_R];
        end
    end

    // Saturating vehicle counters. A clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (rise[CH_A] && (cnt_a_q != CNT_MAX)) begin
                cnt_a_q <= cnt_a_q + CNT_W'(1);
            end
            if (rise[CH_B] && (cnt_b_q != CNT_MAX)) begin
                cnt_b_q <= cnt_b_q + CNT_W'(1);
            end
        end
    end

    assign t_a      = deb_q[CH_A];
    assign t_b      = deb_q[CH_B];
    assign p        = p_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign cnt_a    = cnt_a_q;
    assign cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_traffic_input_cond.sv
// Directed bench for traffic_input_cond. Two instances share the same
// stimulus: u_dut has 8-bit counters, and u_dut2 has 2-bit counters so that
// saturation can be observed. Before each clock edge, the expected outputs
// after that edge are pushed onto a scoreboard. After the edge they are popped
// and compared.
module tb_traffic_input_cond;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_a;
    logic       raw_b;
    logic       btn_p;
    logic       btn_r;
    logic       cnt_clr;

    logic       t_a, t_b, p, r, conflict;
    logic [7:0] cnt_a, cnt_b;
    logic       t_a2, t_b2, p2, r2, conflict2;
    logic [1:0] cnt_a2, cnt_b2;

    // Expected output state, updated by the directed steps below.
    logic e_ta, e_tb, e_p, e_r, e_cf;
    int   e_ca, e_cb, e_ca2, e_cb2;

    typedef struct {
        string       tag;
        logic [29:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    traffic_input_cond #(.DB_CYCLES(DB), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b),
        .btn_p(btn_p), .btn_r(btn_r), .cnt_clr(cnt_clr),
        .t_a(t_a), .t_b(t_b), .p(p), .r(r), .conflict(conflict),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    traffic_input_cond #(.DB_CYCLES(DB), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b),
        .btn_p(btn_p), .btn_r(btn_r), .cnt_clr(cnt_clr),
        .t_a(t_a2), .t_b(t_b2), .p(p2), .r(r2), .conflict(conflict2),
        .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] exp_vec();
        return {e_ta, e_tb, e_p, e_r, e_cf, 8'(e_ca), 8'(e_cb),
                e_ta, e_tb, e_p, e_r, e_cf, 2'(e_ca2), 2'(e_cb2)};
    endfunction

    function automatic string fmt(input logic [29:0] v);
        return $sformatf("t_a=%b t_b=%b p=%b r=%b conflict=%b cnt_a=%0d cnt_b=%0d | w2: t_a=%b t_b=%b p=%b r=%b conflict=%b cnt_a=%0d cnt_b=%0d",
                         v[29], v[28], v[27], v[26], v[25], v[24:17], v[16:9],
                         v[8], v[7], v[6], v[5], v[4], v[3:2], v[1:0]);
    endfunction

    // Push the expectation, clock once, then pop and compare.
    task automatic tick(input string tag);
        exp_t        e;
        logic [29:0] obs;
        e.tag = tag;
        e.vec = exp_vec();
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {t_a, t_b, p, r, conflict, cnt_a, cnt_b,
               t_a2, t_b2, p2, r2, conflict2, cnt_a2, cnt_b2};
        n_cmp++;
        assert (obs === e.vec) else begin
            n_err++;
            $error("FAIL %s: observed %s ; expected %s", e.tag, fmt(obs), fmt(e.vec));
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(tag);
        end
    endtask

    task automatic inc_a();
        if (e_ca < 255) e_ca++;
        if (e_ca2 < 3) e_ca2++;
    endtask

    task automatic inc_b();
        if (e_cb < 255) e_cb++;
        if (e_cb2 < 3) e_cb2++;
    endtask

    task automatic clr_all();
        e_ca = 0; e_cb = 0; e_ca2 = 0; e_cb2 = 0;
    endtask

    initial begin
        e_ta = 0; e_tb = 0; e_p = 0; e_r = 0; e_cf = 0;
        clr_all();

        // Reset is held with the road detectors and parade-start high.
        rst = 1; raw_a = 1; raw_b = 1; btn_p = 1; btn_r = 0; cnt_clr = 0;
        ticks(5, "reset_hold");
        rst = 0;
        ticks(DB + 1, "reset_release_wait");
        e_ta = 1; e_tb = 1;
        tick("reset_release_t_rise");                 // edge 6
        e_p = 1; inc_a(); inc_b();
        tick("reset_release_p_cnt");                  // edge 7
        e_p = 0;
        ticks(3, "reset_release_hold");

        // Clean step on raw_a: the fall does not count; the rise counts one edge later.
        raw_a = 0;
        ticks(DB + 1, "step_fall_wait");
        e_ta = 0;
        tick("step_fall_t_a");
        ticks(3, "step_fall_cnt_hold");
        raw_a = 1;
        ticks(DB + 1, "step_rise_wait");
        e_ta = 1;
        tick("step_rise_t_a");
        inc_a();
        tick("step_rise_cnt_a");
        ticks(2, "step_rise_hold");

        // Bounce on raw_b: 2-cycle highs separated by 1-cycle lows never debounce.
        raw_b = 0;
        ticks(DB + 1, "b_fall_wait");
        e_tb = 0;
        tick("b_fall_t_b");
        ticks(2, "b_fall_hold");
        for (int i = 0; i < 21; i++) begin
            raw_b = (i % 3 != 2);
            tick("bounce_b");
        end
        raw_b = 0;
        ticks(8, "bounce_b_quiet");

        // Release of parade-start gives no pulse. A 50-cycle hold gives exactly one pulse.
        btn_p = 0;
        ticks(10, "btn_p_release");
        btn_p = 1;
        ticks(DB + 2, "btn_p_wait");
        e_p = 1;
        tick("btn_p_pulse");
        e_p = 0;
        ticks(43, "btn_p_hold");
        btn_p = 0;
        ticks(10, "btn_p_release2");
        btn_r = 1;
        ticks(DB + 2, "btn_r_wait");
        e_r = 1;
        tick("btn_r_pulse");
        e_r = 0;
        ticks(20, "btn_r_hold");
        btn_r = 0;
        ticks(10, "btn_r_release");

        // Simultaneous rise gives conflict only.
        btn_p = 1; btn_r = 1;
        ticks(DB + 2, "sim_wait");
        e_cf = 1;
        tick("sim_conflict");
        e_cf = 0;
        ticks(10, "sim_hold");
        btn_p = 0; btn_r = 0;
        ticks(10, "sim_release");

        // Rises on adjacent cycles produce two independent pulses.
        btn_p = 1;
        tick("adj_p_first");
        btn_r = 1;
        ticks(DB + 1, "adj_wait");
        e_p = 1;
        tick("adj_p_pulse");
        e_p = 0; e_r = 1;
        tick("adj_r_pulse");
        e_r = 0;
        ticks(5, "adj_hold");
        btn_p = 0; btn_r = 0;
        ticks(10, "adj_release");

        // Clear, then saturation on the 2-bit instance: 1,2,3,3,3.
        cnt_clr = 1;
        clr_all();
        tick("cnt_clr");
        cnt_clr = 0;
        ticks(2, "cnt_clr_hold");
        for (int k = 0; k < 5; k++) begin
            raw_a = 0;
            ticks(DB + 1, "sat_fall_wait");
            e_ta = 0;
            tick("sat_fall_t_a");
            ticks(2, "sat_fall_hold");
            raw_a = 1;
            ticks(DB + 1, "sat_rise_wait");
            e_ta = 1;
            tick("sat_rise_t_a");
            inc_a();
            tick("sat_inc");
            ticks(2, "sat_hold");
        end

        // Clear on the same cycle as a 6th increment wins.
        raw_a = 0;
        ticks(DB + 1, "clr_inc_fall_wait");
        e_ta = 0;
        tick("clr_inc_fall");
        ticks(2, "clr_inc_fall_hold");
        raw_a = 1;
        ticks(DB + 1, "clr_inc_rise_wait");
        e_ta = 1;
        tick("clr_inc_rise");
        cnt_clr = 1;
        clr_all();
        tick("clr_vs_inc");
        cnt_clr = 0;
        ticks(2, "clr_vs_inc_hold");

        // Reset mid-operation discards a pending parade pulse and clears all state.
        btn_p = 1;
        ticks(DB + 2, "mid_rst_pending");
        rst = 1;
        e_ta = 0;
        clr_all();
        tick("mid_reset");
        rst = 0;
        ticks(DB + 1, "post_reset_wait");
        e_ta = 1;
        tick("post_reset_t_a");
        e_p = 1;
        inc_a();
        tick("post_reset_p_cnt");
        e_p = 0;
        ticks(3, "post_reset_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
